reset_sequencer: RTL and testbench

- Parametrised successor of the fixed five-state reset controller.
- Releases NUM_CH downstream block resets one at a time, on programmable per-phase durations, then asserts a display enable.
- Adds a start/abort handshake, runtime-writable durations, a status interface and restart without a global reset.
- Sits at top level and drives the mem/PE/3x3/2x2/display reset pins of the compute pipeline.

---
 rtl/reset_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_reset_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Releases NUM_CH downstream block resets one at a time. Each channel release
// is preceded by a timed phase of programmable length, and a final timed phase
// precedes the display enable. NUM_CH+1 phases in total. Phase p lasts
// dur[p]+1 cycles. Durations can be rewritten at runtime. The sequence can be
// restarted or aborted without a global reset.
//
// Optional feature (compile-time macro RSTSEQ_STEP_EN):
//   When defined, an extra 'step' input follows 'abort'. A step pulse in RUN
//   forces the current phase to expire in that cycle. A same-cycle abort still
//   takes priority. When undefined, phases expire on their durations only.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous, active-high reset
//   start      in   one-cycle request to begin; honoured in IDLE or DONE
//   abort      in   one-cycle request to return to IDLE; honoured in RUN/DONE
//   step       in   (RSTSEQ_STEP_EN only) force current phase to expire
//   dur_we     in   duration write strobe
//   dur_idx    in   duration entry to write (0..NUM_CH; larger is ignored)
//   dur_wdata  in   duration value in cycles
//   ch_rst     out  per-channel reset, 1 = held in reset
//   disp_en    out  display enable, high only in DONE
//   busy       out  high while in RUN
//   done       out  one-cycle pulse on entry to DONE
//   phase      out  current phase index (0 outside RUN)
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned DEFAULT_DUR = 10000,
  parameter bit          AUTO_START  = 1'b1,
  localparam int         IDX_W       = $clog2(NUM_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
`ifdef RSTSEQ_STEP_EN
  input  logic              step,
`endif
  input  logic              dur_we,
  input  logic [IDX_W-1:0]  dur_idx,
  input  logic [CNT_W-1:0]  dur_wdata,
  output logic [NUM_CH-1:0] ch_rst,
  output logic              disp_en,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  phase
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_PHASE = IDX_W'(NUM_CH);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    phase_d;
  logic [CNT_W-1:0]    dur_q [NUM_CH+1];
  logic                auto_q;

  logic                start_eff;
  logic                step_eff;
  logic                expire;
  logic                done_d;
  logic                busy_d;
  logic                disp_en_d;
  logic [NUM_CH-1:0]   ch_rst_d;

`ifdef RSTSEQ_STEP_EN
  assign step_eff = step;
`else
  assign step_eff = 1'b0;
`endif

  // The first cycle out of reset acts as a start request when AUTO_START is set.
  assign start_eff = start | auto_q;

  // 'phase' is the live phase register; it is held at 0 outside RUN, so the
  // duration lookup is always in range.
  assign expire = (cnt_q == dur_q[phase]) | step_eff;

  // ---------------------------------------------------------------------------
  // Next-state logic. Outputs are derived from the *next* state so that the
  // registered outputs line up with the state they describe.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d = state_q;
    phase_d = phase;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // abort is meaningless here; start (or autostart) always wins.
        if (start_eff) begin
          state_d = S_RUN;
          phase_d = '0;
          cnt_d   = '0;
        end
      end

      S_RUN: begin
        // start is ignored while running; abort has top priority.
        if (abort) begin
          state_d = S_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (expire) begin
          cnt_d = '0;
          if (phase == LAST_PHASE) begin
            state_d = S_DONE;
            phase_d = '0;
            done_d  = 1'b1;
          end else begin
            phase_d = phase + IDX_W'(1);
          end
        end else begin
          // Counter wraps modulo 2^CNT_W if a duration was shortened below it.
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
          phase_d = '0;
          cnt_d   = '0;
        end else if (start_eff) begin
          state_d = S_RUN;
          phase_d = '0;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        phase_d = '0;
        cnt_d   = '0;
      end
    endcase

    busy_d    = (state_d == S_RUN);
    disp_en_d = (state_d == S_DONE);

    // Channels below the current phase are released; the rest stay held.
    ch_rst_d = '1;
    if (state_d == S_DONE) begin
      ch_rst_d = '0;
    end else if (state_d == S_RUN) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_rst_d[i] = (i >= int'(phase_d));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State, counter, duration table and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples
    // values from before this edge regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase   <= '0;
      ch_rst  <= '1;
      disp_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      auto_q  <= AUTO_START;
      // NOTE: the duration table is deliberately reset: software relies on
      // rst restoring DEFAULT_DUR. Do not strip this reset to save area.
      for (int i = 0; i <= NUM_CH; i++) begin
        dur_q[i] <= CNT_W'(DEFAULT_DUR);
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase   <= phase_d;
      ch_rst  <= ch_rst_d;
      disp_en <= disp_en_d;
      busy    <= busy_d;
      done    <= done_d;
      auto_q  <= 1'b0;
      // A write to the live phase's entry is seen by the compare next cycle.
      if (dur_we && (int'(dur_idx) <= NUM_CH)) begin
        dur_q[dur_idx] <= dur_wdata;
      end
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// -----------------------------------------------------------------------------
// tb_reset_sequencer
//
// Drives reset_sequencer through directed scenarios and a randomized stretch.
// Every cycle the DUT outputs are compared against a behavioural model that
// tracks the current mode, the phase index and the cycle number at which the
// phase began. A phase expires once (now - phase_start) equals dur+1.
// -----------------------------------------------------------------------------
module tb_reset_sequencer;

  localparam int          NUM_CH = 4;
  localparam int          CNT_W  = 32;
  localparam int unsigned DEF    = 10000;
  localparam int          IDX_W  = $clog2(NUM_CH + 1);
  localparam int          ALL    = (1 << NUM_CH) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic              step;
  logic              dur_we;
  logic [IDX_W-1:0]  dur_idx;
  logic [CNT_W-1:0]  dur_wdata;
  logic [NUM_CH-1:0] ch_rst;
  logic              disp_en;
  logic              busy;
  logic              done;
  logic [IDX_W-1:0]  phase;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DUR (DEF),
    .AUTO_START  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
`ifdef RSTSEQ_STEP_EN
    .step      (step),
`endif
    .dur_we    (dur_we),
    .dur_idx   (dur_idx),
    .dur_wdata (dur_wdata),
    .ch_rst    (ch_rst),
    .disp_en   (disp_en),
    .busy      (busy),
    .done      (done),
    .phase     (phase)
  );

  // ---------------------------------------------------------------- model
  // mode: 0 = idle, 1 = running, 2 = done
  int          m_mode;
  int          m_p;
  logic [31:0] m_cyc;
  logic [31:0] m_start;
  logic [31:0] m_dur [NUM_CH+1];
  bit          m_auto;
  bit          m_done;

  task automatic model_edge(input bit r, input bit s, input bit a, input bit st,
                            input bit we, input int idx, input logic [31:0] wd);
    bit go;
    m_cyc  = m_cyc + 32'd1;
    m_done = 1'b0;
    if (r) begin
      m_mode = 0;
      m_p    = 0;
      m_auto = 1'b1;
      for (int i = 0; i <= NUM_CH; i++) m_dur[i] = DEF;
      return;
    end
    go     = s | m_auto;
    m_auto = 1'b0;
    if (m_mode == 0) begin
      if (go) begin
        m_mode = 1; m_p = 0; m_start = m_cyc;
      end
    end else if (m_mode == 1) begin
      if (a) begin
        m_mode = 0; m_p = 0;
      end else if (st || ((m_cyc - m_start) == (m_dur[m_p] + 32'd1))) begin
        if (m_p == NUM_CH) begin
          m_mode = 2; m_p = 0; m_done = 1'b1;
        end else begin
          m_p = m_p + 1; m_start = m_cyc;
        end
      end
    end else begin
      if (a) begin
        m_mode = 0; m_p = 0;
      end else if (go) begin
        m_mode = 1; m_p = 0; m_start = m_cyc;
      end
    end
    // The write lands after this edge's compare has used the old value.
    if (we && idx <= NUM_CH) m_dur[idx] = wd;
  endtask

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    int exp_ch;
    exp_ch = (m_mode == 1) ? ((ALL << m_p) & ALL) : ((m_mode == 2) ? 0 : ALL);
    check("ch_rst",  32'(ch_rst),  32'(exp_ch));
    check("disp_en", 32'(disp_en), 32'(m_mode == 2));
    check("busy",    32'(busy),    32'(m_mode == 1));
    check("done",    32'(done),    32'(m_done));
    check("phase",   32'(phase),   32'((m_mode == 1) ? m_p : 0));
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare at +1.
  task automatic tick(input bit r, input bit s, input bit a, input bit st,
                      input bit we, input int idx, input logic [31:0] wd);
    rst       = r;
    start     = s;
    abort     = a;
    step      = st;
    dur_we    = we;
    dur_idx   = idx[IDX_W-1:0];
    dur_wdata = wd;
    @(posedge clk);
    model_edge(r, s, a, st, we, idx, wd);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0, 0, 32'd0);
  endtask

  // Run until the model reaches the given running phase, within a budget.
  task automatic run_to_phase(input int p, input string tag);
    for (int i = 0; i < 200; i++) begin
      if (m_mode == 1 && m_p == p) break;
      idle(1);
    end
    check(tag, 32'(phase), 32'(p));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    m_cyc = 32'd0; m_start = 32'd0; m_mode = 0; m_p = 0; m_auto = 1'b0; m_done = 1'b0;
    for (int i = 0; i <= NUM_CH; i++) m_dur[i] = DEF;

    // Reset state.
    tick(1, 0, 0, 0, 0, 0, 32'd0);
    tick(1, 0, 0, 0, 0, 0, 32'd0);

    // Timed release with autostart; durations {2,3,0,1,4} written as it runs.
    tick(0, 0, 0, 0, 1, 0, 32'd2);
    tick(0, 0, 0, 0, 1, 1, 32'd3);
    tick(0, 0, 0, 0, 1, 2, 32'd0);
    tick(0, 0, 0, 0, 1, 3, 32'd1);
    tick(0, 0, 0, 0, 1, 4, 32'd4);
    idle(14);
    check("timed_done_disp", 32'(disp_en), 32'd1);

    // Reprogram while idle and restart twice.
    tick(0, 0, 1, 0, 0, 0, 32'd0);
    tick(0, 0, 0, 0, 1, 0, 32'd5);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    idle(22);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    check("restart_ch_rst", 32'(ch_rst), 32'(ALL));
    idle(22);

    // Abort mid-sequence with a simultaneous start.
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    run_to_phase(2, "reach_phase2");
    tick(0, 1, 1, 0, 0, 0, 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    idle(2);

    // Ignored requests: abort in IDLE, start in RUN, out-of-range write.
    tick(0, 0, 1, 0, 0, 0, 32'd0);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    idle(2);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    tick(0, 0, 0, 0, 1, 7, 32'd0);
    tick(0, 0, 0, 0, 1, 5, 32'd0);
    idle(25);

    // Randomized stretch, including writes to live and out-of-range entries.
    for (int i = 0; i < 600; i++) begin
      bit s, a, we;
      s  = ($urandom_range(19) == 0);
      a  = ($urandom_range(39) == 0);
      we = ($urandom_range(7) == 0);
      tick(0, s, a, 0, we, int'($urandom_range(7)), 32'($urandom_range(6)));
    end

    // Synchronous reset during phase 3; defaults return.
    tick(0, 0, 1, 0, 0, 0, 32'd0);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    run_to_phase(3, "reach_phase3");
    tick(1, 0, 0, 0, 0, 0, 32'd0);
    check("rst_ch_rst", 32'(ch_rst), 32'(ALL));
    idle(1);
    idle(int'(DEF));
    check("default_phase0_end", 32'(phase), 32'd0);
    idle(1);
    check("default_phase1", 32'(phase), 32'd1);

`ifdef RSTSEQ_STEP_EN
    // Step-driven sequence with long durations.
    for (int i = 0; i <= NUM_CH; i++) tick(0, 0, 0, 0, 1, i, 32'd1000);
    tick(0, 0, 1, 0, 0, 0, 32'd0);
    tick(0, 1, 0, 0, 0, 0, 32'd0);
    for (int k = 0; k < NUM_CH + 1; k++) begin
      tick(0, 0, 0, 1, 0, 0, 32'd0);
      idle(1);
    end
    check("step_disp_en", 32'(disp_en), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
